led_pwm_driver: RTL and testbench

//  Downstream of the 8-bit LED PIO: takes its out_port pattern and drives the

---
 rtl/led_pwm_driver.sv | 105 ++++++++++
 tb/tb_led_pwm_driver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_driver.sv
`default_nettype none
// ============================================================================
// led_pwm_driver : glitch-free global-brightness PWM for the board LED pins.
// Optional per-LED fade toward the target level via LED_PWM_FADE_EN.
// Revision 1.0
// ============================================================================
module led_pwm_driver #(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 50,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_pattern,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_start
);

    localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] FULL   = '1;
    localparam logic              POL      = (ACTIVE_LOW != 0);
    localparam logic [NUM_LEDS-1:0] LEDS_OFF = {NUM_LEDS{POL}};

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0] lit;
    logic                tick;
    logic                wrap;

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (pwm_cnt == FULL);

`ifdef LED_PWM_FADE_EN
    // Each LED's level walks one step per period toward its target; the level
    // alone decides the duty, so a cleared pattern bit fades out rather than snapping off.
    logic [PWM_BITS-1:0] level [NUM_LEDS];

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_fade
            logic [PWM_BITS-1:0] target;
            assign target = led_pattern[i] ? brightness : '0;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    level[i] <= '0;
                end else if (!enable) begin
                    level[i] <= target;
                end else if (wrap) begin
                    if (level[i] < target)
                        level[i] <= level[i] + 1'b1;
                    else if (level[i] > target)
                        level[i] <= level[i] - 1'b1;
                end
            end

            assign lit[i] = (level[i] == FULL) || (pwm_cnt < level[i]);
        end
    endgenerate
`else
    logic [NUM_LEDS-1:0] shadow_pat;
    logic [PWM_BITS-1:0] duty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_pat <= '0;
            duty       <= '0;
        end else if (!enable || wrap) begin
            shadow_pat <= led_pattern;
            duty       <= brightness;
        end
    end

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lit
            assign lit[i] = shadow_pat[i] && ((duty == FULL) || (pwm_cnt < duty));
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
            led_out      <= LEDS_OFF;
        end else if (!enable) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
            led_out      <= LEDS_OFF;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            period_start <= wrap;
            led_out      <= lit ^ LEDS_OFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// Bench for led_pwm_driver (default build): phase-based reference model plus
// directed checks of reset, duty, boundary latching and enable behaviour.
`timescale 1ns/1ps
module tb_led_pwm_driver;

    localparam int PB     = 4;
    localparam int PS     = 2;
    localparam int PERIOD = PS * (1 << PB);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] led_pattern = 8'h00;
    logic [3:0] brightness = 4'h0;
    logic       enable = 1'b0;
    logic [7:0] led_out;
    logic       period_start;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .NUM_LEDS   (8),
        .PWM_BITS   (PB),
        .PRESCALE   (PS),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .led_pattern  (led_pattern),
        .brightness   (brightness),
        .enable       (enable),
        .led_out      (led_out),
        .period_start (period_start)
    );

    int tests = 0;
    int fails = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: elapsed clk count within the period gives the PWM step.
    int         m_phase = 0;
    logic [7:0] m_pat = 8'h00;
    logic [3:0] m_bri = 4'h0;
    logic [7:0] exp_led = 8'hFF;
    logic       exp_ps = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_phase = 0; m_pat = 8'h00; m_bri = 4'h0;
                exp_led = 8'hFF; exp_ps = 1'b0;
            end else if (!enable) begin
                m_phase = 0; m_pat = led_pattern; m_bri = brightness;
                exp_led = 8'hFF; exp_ps = 1'b0;
            end else begin
                for (int i = 0; i < 8; i++)
                    exp_led[i] = !(m_pat[i] && (m_bri == 4'hF || (m_phase / PS) < int'(m_bri)));
                m_phase = m_phase + 1;
                exp_ps  = 1'b0;
                if (m_phase == PERIOD) begin
                    m_phase = 0; m_pat = led_pattern; m_bri = brightness; exp_ps = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (run_chk) begin
                chk("cycle led_out", 32'(led_out), 32'(exp_led));
                chk("cycle period_start", 32'(period_start), 32'(exp_ps));
            end
        end
    end

    task automatic wait_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 4 * PERIOD);
        if (!period_start) chk("period_start timeout", 32'd0, 32'd1);
    endtask

    // Scan one full period following a period_start and count deviations.
    task automatic window_all(input string nm, input logic [7:0] exp);
        int bad = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            if (led_out !== exp) bad++;
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    initial begin
        int zeros, upper_bad, pulses, n;

        repeat (3) @(negedge clk);
        run_chk = 1'b1;
        chk("reset led_out", 32'(led_out), 32'hFF);
        chk("reset period_start", 32'(period_start), 32'd0);

        // Duty 4/16 on LED0 only
        reset_n = 1'b1; led_pattern = 8'h01; brightness = 4'd4; enable = 1'b1;
        wait_ps();
        zeros = 0; upper_bad = 0; pulses = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            if (led_out[0] == 1'b0) zeros++;
            if (led_out[7:1] !== 7'h7F) upper_bad++;
            if (period_start) pulses++;
        end
        chk("duty4 on-time", 32'(zeros), 32'd8);
        chk("duty4 upper pins", 32'(upper_bad), 32'd0);
        chk("pulses per period", 32'(pulses), 32'd1);

        // Mid-period pattern change must wait for the boundary
        repeat (2) @(negedge clk);
        led_pattern = 8'h80;
        @(negedge clk);
        chk("pattern held mid-period", 32'(led_out), 32'hFE);
        wait_ps();
        chk("pins at period_start", 32'(led_out), 32'hFF);
        @(negedge clk);
        chk("pattern applied", 32'(led_out), 32'h7F);

        // Brightness extremes
        led_pattern = 8'hFF; brightness = 4'd0;
        wait_ps();
        window_all("duty0 dark", 8'hFF);
        brightness = 4'hF;
        wait_ps();
        window_all("duty15 full on", 8'h00);

        // Enable low then high
        enable = 1'b0;
        @(negedge clk);
        chk("disable pins off", 32'(led_out), 32'hFF);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (period_start) pulses++;
        end
        chk("no pulse while disabled", 32'(pulses), 32'd0);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 4 * PERIOD);
        chk("first pulse after enable", 32'(n), 32'(PERIOD));

        // Asynchronous reset right while period_start is high
        wait_ps();
        #2 reset_n = 1'b0;
        #1;
        chk("async reset led_out", 32'(led_out), 32'hFF);
        chk("async reset period_start", 32'(period_start), 32'd0);
        repeat (3) @(negedge clk);
        chk("reset hold led_out", 32'(led_out), 32'hFF);
        reset_n = 1'b1;
        repeat (PERIOD + 8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
